nmr_pll_reconfig_ctrl: RTL
==========================

# nmr_pll_reconfig_ctrl

Avalon-MM–controlled reconfiguration master for the NMR system fractional PLL. It holds shadow copies of the PLL counter, fractional and loop settings, streams the modified ones onto the 64-bit `reconfig_to_pll` bus, and triggers an apply. It then monitors `reconfig_from_pll` and `locked` until the new frequency settles or a timeout occurs. It sits between the host-side Avalon interconnect and the PLL's `reconfig_to_pll`/`reconfig_from_pll` ports.

## Interface
- `TIMEOUT_CYCLES`, 65535: maximum cycles spent in WAIT_BUSY or WAIT_LOCK before an error is flagged.
- `RST_CYCLES`, 16: PLL reset pulse width in cycles; used only with `PLL_RECONFIG_RESET_EN`.
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset; synchronous, active-low.
- `avs_address`  in  3  word address.
- `avs_read`  in  1  Avalon read strobe.
- `avs_write`  in  1  Avalon write strobe.
- `avs_writedata`  in  32  write data.
- `avs_readdata`  out  32  read data.
- `avs_waitrequest`  out  1  Avalon stall.
- `pll_locked`  in  1  PLL lock indicator; asynchronous, passed through a 2-flop synchronizer.
- `reconfig_from_pll`  in  64  `[0]` PLL busy applying; `[63:1]` ignored.
- `reconfig_to_pll`  out  64  `[31:0]` cfg data; `[37:32]` cfg address; `[38]` cfg write strobe; `[39]` apply pulse; `[40]` PLL reset; `[63:41]` tied to 0.

## Operation
Register map (word addresses):
- 0 STATUS, read-only:
  - `[0]` busy (FSM not IDLE).
  - `[1]` done, sticky.
  - `[2]` timeout error, sticky.
  - `[3]` synchronized lock.
- 1 START, write-only. Any write while IDLE clears done/error and launches the sequence. A write while not IDLE is accepted and ignored.
- 2 M counter, 3 N counter, 4 C0 counter: `[7:0]` hi, `[15:8]` lo, `[16]` bypass, `[17]` odd-duty; upper bits read as 0.
- 5 fractional K, 32 bits.
- 6 bandwidth `[3:0]`; 7 charge pump `[2:0]`.

Shadow registers and dirty bits:
- Each shadow register 2–7 has a dirty bit, set on write and cleared when that register is transferred.
- Writes to registers 2–7 while not IDLE stall (waitrequest held) until IDLE.

FSM states:
- IDLE: START → XFER if any dirty bit is set, else APPLY.
- XFER: one cycle per dirty register, ascending address order. Drive `[37:32]` = register address, `[31:0]` = value, `[38]` = 1. Go to APPLY after the last dirty register.
- APPLY: `[39]` = 1 for exactly one cycle → WAIT_BUSY.
- WAIT_BUSY: wait for `from_pll[0]` = 0, but only after a 2-cycle grace period → PRST if `PLL_RECONFIG_RESET_EN` is defined, else WAIT_LOCK.
- PRST: `[40]` = 1 for `RST_CYCLES` cycles → WAIT_LOCK.
- WAIT_LOCK: synchronized lock = 1 → DONE.
- DONE: set done → IDLE.

Timeout:
- A 17-bit counter is cleared on entry to WAIT_BUSY and to WAIT_LOCK.
- When the count reaches `TIMEOUT_CYCLES`: set error, go to IDLE, done stays 0.

Reset values:
- All outputs 0 except `avs_waitrequest` = 1 during reset.
- Shadow registers 0, dirty bits clear, sticky bits clear, FSM in IDLE.
- Reset mid-sequence takes effect on the next edge: all `reconfig_to_pll` bits drop to 0 and no further strobes are issued.

## Timing
Avalon reads:
- `avs_waitrequest` = 1 on the first cycle of `avs_read`.
- Registered `avs_readdata` is valid in the cycle waitrequest falls, giving a 2-cycle read.

Avalon writes:
- Accepted in the first cycle if not stalled.
- A write whose accept cycle coincides with the FSM entering IDLE is accepted in that cycle.

Sequence latency:
- From the START accept edge, the first XFER strobe appears 1 cycle later.
- The apply pulse follows the last strobe by 1 cycle.
- `reconfig_to_pll[37:0]` holds its last value when not strobing; only `[38]`, `[39]` and `[40]` are pulse-qualified.
- Simultaneous START write and lock loss in IDLE: START wins; lock is re-sampled in WAIT_LOCK.

## Configuration
- `PLL_RECONFIG_RESET_EN` defined: the PRST state exists, and `[40]` pulses high for `RST_CYCLES` cycles between WAIT_BUSY and WAIT_LOCK.
- Macro undefined: no PRST state, `[40]` is constant 0, and WAIT_BUSY goes directly to WAIT_LOCK.

## Test plan
- Write M=`0x0404`, K=`0x4189374C`, then START → exactly two strobes (addr 2 data `0x0404`, then addr 5 data `0x4189374C`), then one apply pulse. Busy drops when `from_pll[0]` falls and lock rises; STATUS reads `0xA` (done + locked).
- START with no dirty registers → no `[38]` strobe; apply pulse 1 cycle after accept.
- Hold `from_pll[0]` = 1 forever with `TIMEOUT_CYCLES`=100 → error set about 100 cycles after WAIT_BUSY entry; STATUS = `0x4`; next START clears it.
- Write register 3 during a sequence → waitrequest stays high until IDLE; the value is then captured and dirty, but not transferred until the next START.
- Deassert `rst_n` during XFER → on the next edge all `reconfig_to_pll` = 0, STATUS = 0, shadow reads 0.
- With `PLL_RECONFIG_RESET_EN`, `RST_CYCLES`=16 → `[40]` high for exactly 16 cycles after busy falls; absent without the macro.

Source files
------------

// File: rtl/nmr_pll_reconfig_ctrl.sv
// Avalon-MM reconfiguration master for the NMR fractional PLL: shadow registers, dirty-only streaming, apply, lock wait.
// Define PLL_RECONFIG_RESET_EN to insert the PLL reset pulse (PRST) between busy release and lock wait.
module nmr_pll_reconfig_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned RST_CYCLES     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  input  logic        pll_locked,
  input  logic [63:0] reconfig_from_pll,
  output logic [63:0] reconfig_to_pll
);

  typedef enum logic [2:0] {
    IDLE, XFER, APPLY, WAIT_BUSY,
`ifdef PLL_RECONFIG_RESET_EN
    PRST,
`endif
    WAIT_LOCK, DONE
  } state_t;

`ifdef PLL_RECONFIG_RESET_EN
  localparam state_t AFTER_BUSY = PRST;
`else
  localparam state_t AFTER_BUSY = WAIT_LOCK;
`endif
  localparam logic [16:0] TMO      = 17'(TIMEOUT_CYCLES);
  localparam logic [16:0] RST_LAST = 17'(RST_CYCLES - 1);

  state_t      state, state_nxt;
  logic [16:0] cnt;
  logic [1:0]  lock_ff;
  logic        lock_sync;
  logic [17:0] m_q, n_q, c0_q;
  logic [31:0] k_q;
  logic [3:0]  bw_q;
  logic [2:0]  cp_q;
  logic [7:2]  dirty, sel_mask;
  logic [2:0]  sel;
  logic        found;
  logic        done_q, err_q, rd_done;
  logic        idle, stall, wr_accept, start, busy_clear, tmo_hit;
  logic [31:0] regs [8];
  logic [5:0]  cfg_addr_q, addr_nxt;
  logic [31:0] cfg_data_q, data_nxt;
  logic        strobe_q, strobe_nxt, apply_q, apply_nxt;
  logic        prst_out;
  logic        unused_cfg;

  assign lock_sync       = lock_ff[1];
  assign idle            = (state == IDLE);
  assign stall           = avs_write && (avs_address >= 3'd2) && !idle;
  assign avs_waitrequest = !rst_n || (avs_read && !rd_done) || stall;
  assign wr_accept       = avs_write && !avs_waitrequest;
  assign start           = wr_accept && (avs_address == 3'd1) && idle;
  // Two-cycle grace so a PLL that raises busy a little after apply is not missed.
  assign busy_clear      = (cnt >= 17'd2) && !reconfig_from_pll[0];
  assign tmo_hit         = ((state == WAIT_BUSY && !busy_clear) ||
                            (state == WAIT_LOCK && !lock_sync)) && (cnt == TMO);
  assign unused_cfg      = ^{reconfig_from_pll[63:1], RST_LAST};

  always_comb begin
    regs[0] = {28'd0, lock_sync, err_q, done_q, !idle};
    regs[1] = '0;
    regs[2] = {14'd0, m_q};
    regs[3] = {14'd0, n_q};
    regs[4] = {14'd0, c0_q};
    regs[5] = k_q;
    regs[6] = {28'd0, bw_q};
    regs[7] = {29'd0, cp_q};
  end

  // Lowest-addressed dirty register is the one transferred this XFER cycle.
  always_comb begin
    sel      = 3'd2;
    sel_mask = '0;
    found    = 1'b0;
    for (int unsigned i = 2; i < 8; i++) begin
      if (dirty[i] && !found) begin
        found       = 1'b1;
        sel         = 3'(i);
        sel_mask[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + 17'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (start) state_nxt = (dirty != '0) ? XFER : APPLY;
      XFER:      if ((dirty & ~sel_mask) == '0) state_nxt = APPLY;
      APPLY:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (busy_clear) state_nxt = AFTER_BUSY;
                 else if (tmo_hit) state_nxt = IDLE;
`ifdef PLL_RECONFIG_RESET_EN
      PRST:      if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
`endif
      WAIT_LOCK: if (lock_sync) state_nxt = DONE;
                 else if (tmo_hit) state_nxt = IDLE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    strobe_nxt = 1'b0;
    apply_nxt  = (state == APPLY);
    addr_nxt   = cfg_addr_q;
    data_nxt   = cfg_data_q;
    if (state == XFER) begin
      strobe_nxt = 1'b1;
      addr_nxt   = {3'b000, sel};
      data_nxt   = regs[sel];
    end
  end

`ifdef PLL_RECONFIG_RESET_EN
  logic prst_q;
  always_ff @(posedge clk) begin
    if (!rst_n) prst_q <= 1'b0;
    else        prst_q <= (state == PRST);
  end
  assign prst_out = prst_q;
`else
  assign prst_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_ff      <= '0;
      rd_done      <= 1'b0;
      avs_readdata <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      dirty        <= '0;
      m_q          <= '0;
      n_q          <= '0;
      c0_q         <= '0;
      k_q          <= '0;
      bw_q         <= '0;
      cp_q         <= '0;
      cfg_addr_q   <= '0;
      cfg_data_q   <= '0;
      strobe_q     <= 1'b0;
      apply_q      <= 1'b0;
    end else begin
      lock_ff <= {lock_ff[0], pll_locked};
      rd_done <= avs_read && !rd_done;
      if (avs_read && !rd_done) avs_readdata <= regs[avs_address];
      if (start) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (tmo_hit) err_q <= 1'b1;
      if (state == DONE) done_q <= 1'b1;
      if (state == XFER) dirty <= dirty & ~sel_mask;
      if (wr_accept) begin
        unique case (avs_address)
          3'd2:    begin m_q  <= avs_writedata[17:0]; dirty[2] <= 1'b1; end
          3'd3:    begin n_q  <= avs_writedata[17:0]; dirty[3] <= 1'b1; end
          3'd4:    begin c0_q <= avs_writedata[17:0]; dirty[4] <= 1'b1; end
          3'd5:    begin k_q  <= avs_writedata;       dirty[5] <= 1'b1; end
          3'd6:    begin bw_q <= avs_writedata[3:0];  dirty[6] <= 1'b1; end
          3'd7:    begin cp_q <= avs_writedata[2:0];  dirty[7] <= 1'b1; end
          default: ;
        endcase
      end
      cfg_addr_q <= addr_nxt;
      cfg_data_q <= data_nxt;
      strobe_q   <= strobe_nxt;
      apply_q    <= apply_nxt;
    end
  end

  assign reconfig_to_pll = {23'd0, prst_out, apply_q, strobe_q, cfg_addr_q, cfg_data_q};

endmodule
